// File: rtl/bsg_oddr_tx_framer.sv
// Transmit framer feeding bsg_oddr_phy: sends a training pattern after reset,
// then credit-gated two-lane flits (lane0 = low half, sent first).
module bsg_oddr_tx_framer #(
    parameter int width_p             = 4,
    parameter int train_cycles_p      = 64,
    parameter int max_credits_p       = 16,
    parameter int credits_per_token_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [2*width_p-1:0]   data_i,
    output logic                   ready_o,
    input  logic                   token_i,
    output logic [2*width_p+1:0]   phy_data_o,
    output logic                   link_up_o,
    output logic                   credit_err_o
);

    localparam int cw_lp = $clog2(max_credits_p + 1);
    localparam int tw_lp = $clog2(train_cycles_p + 1);

    typedef enum logic {eTRAIN, eACTIVE} state_e;

    state_e                 state_q, state_d;
    logic [tw_lp-1:0]       cnt_q, cnt_d;
    logic [cw_lp-1:0]       credits_q, credits_d;
    logic                   err_q, err_d;
    logic [2*width_p+1:0]   phy_q, phy_d;

    logic [width_p-1:0]     train_lo;
    logic                   accept;
    logic [cw_lp:0]         sum_ext;
    logic                   overflow;

    always_comb begin
        for (int i = 0; i < width_p; i++) train_lo[i] = (i % 2 == 0);
    end

    assign ready_o = (state_q == eACTIVE) && (credits_q != '0);
    assign accept  = v_i & ready_o;

    // One extra bit holds credits + token before saturation; token <= max so it cannot wrap.
    always_comb begin
        sum_ext = {1'b0, credits_q}
                + (token_i ? (cw_lp+1)'(credits_per_token_p) : '0)
                - {{cw_lp{1'b0}}, accept};
        overflow = sum_ext > (cw_lp+1)'(max_credits_p);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        credits_d = credits_q;
        err_d     = err_q;
        phy_d     = '0;
        case (state_q)
            eTRAIN: begin
                phy_d = {1'b0, ~train_lo, 1'b0, train_lo};
                cnt_d = cnt_q + 1'b1;
                // This clock registers the last training word.
                if (cnt_q == tw_lp'(train_cycles_p - 1)) state_d = eACTIVE;
            end
            eACTIVE: begin
                if (accept)
                    phy_d = {1'b1, data_i[2*width_p-1:width_p], 1'b1, data_i[width_p-1:0]};
                if (overflow) begin
                    credits_d = cw_lp'(max_credits_p);
                    err_d     = 1'b1;
                end else begin
                    credits_d = sum_ext[cw_lp-1:0];
                end
            end
            default: state_d = eTRAIN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= eTRAIN;
            cnt_q     <= '0;
            credits_q <= cw_lp'(max_credits_p);
            err_q     <= 1'b0;
            phy_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            phy_q     <= phy_d;
        end
    end

    assign phy_data_o   = phy_q;
    assign link_up_o    = (state_q == eACTIVE);
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_bsg_oddr_tx_framer.sv
// Directed bench for bsg_oddr_tx_framer: training, credit flow, saturation, async reset.
module tb_bsg_oddr_tx_framer;

    localparam int W = 4;
    localparam logic [9:0] TRAIN_W = 10'b0_1010_0_0101;

    logic clk = 0, rst_n = 0, v = 0, tok = 0;
    logic [2*W-1:0] data = '0;
    logic ready, link, err;
    logic [2*W+1:0] phy;

    int checks = 0, errors = 0;

    bsg_oddr_tx_framer #(.width_p(W), .train_cycles_p(64), .max_credits_p(16),
                         .credits_per_token_p(4)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .data_i(data), .ready_o(ready),
        .token_i(tok), .phy_data_o(phy), .link_up_o(link), .credit_err_o(err));

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       tok;
        logic [7:0] d;
        logic [9:0] e_phy;
        logic       e_rdy;
        logic       e_err;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] fl(input logic [7:0] d);
        return {1'b1, d[7:4], 1'b1, d[3:0]};
    endfunction

    task automatic add(input logic vi, input logic t, input logic [7:0] d,
                       input logic [9:0] ep, input logic er, input logic ee);
        vec_t x;
        x.v = vi; x.tok = t; x.d = d; x.e_phy = ep; x.e_rdy = er; x.e_err = ee;
        vecs.push_back(x);
    endtask

    // 64 training clocks; token pulses during training must not change credits.
    task automatic train_check(input string tag);
        for (int i = 0; i < 64; i++) begin
            tok = (i % 7 == 3);
            tick();
            chk({tag, "_train_phy"}, 32'(phy), 32'(TRAIN_W));
            chk({tag, "_train_link"}, 32'(link), 32'(i == 63));
            chk({tag, "_train_ready"}, 32'(ready), 32'(i == 63));
        end
        tok = 0;
    endtask

    initial begin
        logic [7:0] d;
        #2;
        chk("rst_phy", 32'(phy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_link", 32'(link), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk); #3 rst_n = 1;
        train_check("p1");

        // Credits 16: stream 16 flits, ready drops after the 16th.
        for (int k = 0; k < 16; k++) begin
            d = 8'(k * 37 + 5);
            add(1, 0, d, fl(d), k < 15, 0);
        end
        add(1, 0, 8'hAA, 10'h0, 0, 0);
        add(1, 1, 8'hBB, 10'h0, 1, 0);              // token at 0 -> 4
        for (int k = 0; k < 4; k++) begin
            d = 8'(8'hC0 + k);
            add(1, 0, d, fl(d), k < 3, 0);
        end
        add(0, 0, 8'h11, 10'h0, 0, 0);
        add(0, 1, 8'h22, 10'h0, 1, 0);              // -> 4
        for (int k = 0; k < 3; k++) begin           // -> 1
            d = 8'(8'h30 + k);
            add(1, 0, d, fl(d), 1, 0);
        end
        add(1, 1, 8'h5A, fl(8'h5A), 1, 0);          // accept at 1 + token -> 4
        for (int k = 0; k < 4; k++) begin
            d = 8'(8'h60 + k);
            add(1, 0, d, fl(d), k < 3, 0);
        end
        for (int k = 0; k < 4; k++) add(0, 1, 8'h00, 10'h0, 1, 0);  // -> 16
        add(0, 1, 8'h00, 10'h0, 1, 1);              // overflow: saturate, sticky err
        for (int k = 0; k < 16; k++) begin
            d = 8'(k * 91 + 3);
            add(1, 0, d, fl(d), k < 15, 1);
        end
        add(1, 0, 8'hEE, 10'h0, 0, 1);

        foreach (vecs[i]) begin
            v = vecs[i].v; tok = vecs[i].tok; data = vecs[i].d;
            tick();
            chk($sformatf("vec%0d_phy", i), 32'(phy), 32'(vecs[i].e_phy));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e_err));
        end

        // Async reset in the middle of a stream.
        v = 0; tok = 1; tick();                    // credits 4
        tok = 0; v = 1; data = 8'h77; tick();
        chk("mid_phy", 32'(phy), 32'(fl(8'h77)));
        #3 rst_n = 0;
        #1;
        chk("arst_phy", 32'(phy), 0);
        chk("arst_ready", 32'(ready), 0);
        chk("arst_link", 32'(link), 0);
        chk("arst_err", 32'(err), 0);
        #2 rst_n = 1;
        data = 8'h99;
        train_check("p3");
        tick();
        chk("post_flit_phy", 32'(phy), 32'(fl(8'h99)));
        chk("post_flit_ready", 32'(ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
